memory1_stage: RTL

First memory stage (MEM1) of the integer pipeline. It sits directly downstream of the execute stage and holds the EX/MEM1 segment register. For loads and stores it issues the address phase to the data cache. It forwards results, register-write information and per-instruction control to MEM2.

---
 rtl/memory1_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/memory1_stage.sv
// memory1_stage: MEM1 pipeline stage holding EX/MEM1 register and issuing data-cache address phase.
// Optional alignment exception via MEM1_ALIGN_CHECK_EN.
module memory1_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [31:0]       ex_result,
  input  logic [31:0]       ex_store_data,
  input  logic [4:0]        ex_rd_index,
  input  logic [2:0]        ex_number_length,
  input  logic [1:0]        ex_memory_rw,
  input  logic              ex_writeback_valid,
  input  logic              ex_writeback_src,
  output logic              mem1_allowin,
  input  logic              flush,
  output logic              dc_req,
  output logic              dc_we,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [1:0]        dc_size,
  output logic [3:0]        dc_wstrb,
  output logic [31:0]       dc_wdata,
  input  logic              dc_addr_ok,
  input  logic              mem2_allowin,
  output logic              m1_to_m2_valid,
  output logic [31:0]       mem1_out,
  output logic [4:0]        mem1_rd_index,
  output logic              mem1_rd_we,
  output logic [2:0]        number_length_pass,
  output logic [1:0]        memory_rw_pass,
  output logic              writeback_valid_pass,
  output logic              writeback_src_pass,
  output logic              mem1_ale
);
  typedef enum logic [1:0] {EMPTY, PEND, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] result_q, result_d, sdata_q, sdata_d, addr;
  logic [4:0] rd_q, rd_d;
  logic [2:0] len_q, len_d;
  logic [1:0] rw_q, rw_d, size;
  logic wbv_q, wbv_d, wbs_q, wbs_d;
  logic valid, load, ex_mem, ex_mis;
  assign valid = state_q != EMPTY;
  assign size = len_q[1:0];
  assign ex_mem = ex_memory_rw == 2'b01 || ex_memory_rw == 2'b10;
`ifdef MEM1_ALIGN_CHECK_EN
  function automatic logic mis(input logic [1:0] a, input logic [1:0] s);
    return (s == 2'b01 && a[0]) || (s[1] && a != 2'b00);
  endfunction
  assign ex_mis = ex_mem && mis(ex_result[1:0], ex_number_length[1:0]);
  assign mem1_ale = valid && (rw_q == 2'b01 || rw_q == 2'b10) && mis(result_q[1:0], size);
  assign addr = result_q;
`else
  assign ex_mis = 1'b0;
  assign mem1_ale = 1'b0;
  // Force natural alignment so the cache never sees a lane-crossing access
  assign addr = {result_q[31:2], result_q[1] & ~size[1], result_q[0] & (size == 2'b00)};
`endif
  assign dc_req = state_q == PEND && !flush && !mem1_ale;
  assign dc_we = rw_q == 2'b10;
  assign dc_addr = addr[ADDR_W-1:0];
  assign dc_size = size;
  assign dc_wstrb = rw_q != 2'b10 ? 4'b0000 :
                    size == 2'b00 ? 4'b0001 << addr[1:0] :
                    size == 2'b01 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
  assign dc_wdata = size == 2'b00 ? {4{sdata_q[7:0]}} :
                    size == 2'b01 ? {2{sdata_q[15:0]}} : sdata_q;
  assign m1_to_m2_valid = valid && !flush && mem2_allowin &&
                          (state_q == DONE || (state_q == PEND && dc_addr_ok));
  assign mem1_allowin = !valid || m1_to_m2_valid;
  assign load = ex_valid && mem1_allowin && !flush;
  assign mem1_out = result_q;
  assign mem1_rd_index = rd_q;
  assign mem1_rd_we = valid && wbv_q && !mem1_ale;
  assign number_length_pass = len_q;
  assign memory_rw_pass = rw_q;
  assign writeback_valid_pass = wbv_q;
  assign writeback_src_pass = wbs_q;
  always_comb begin
    state_d = flush ? EMPTY :
              load ? ((ex_mem && !ex_mis) ? PEND : DONE) :
              m1_to_m2_valid ? EMPTY :
              (state_q == PEND && dc_req && dc_addr_ok) ? DONE : state_q;
    result_d = load ? ex_result : result_q;
    sdata_d = load ? ex_store_data : sdata_q;
    rd_d = load ? ex_rd_index : rd_q;
    len_d = load ? ex_number_length : len_q;
    rw_d = load ? ex_memory_rw : rw_q;
    wbv_d = load ? ex_writeback_valid : wbv_q;
    wbs_d = load ? ex_writeback_src : wbs_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      result_q <= '0;
      sdata_q <= '0;
      rd_q <= '0;
      len_q <= '0;
      rw_q <= '0;
      wbv_q <= 1'b0;
      wbs_q <= 1'b0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      sdata_q <= sdata_d;
      rd_q <= rd_d;
      len_q <= len_d;
      rw_q <= rw_d;
      wbv_q <= wbv_d;
      wbs_q <= wbs_d;
    end
  end
endmodule
